// File: rtl/pair_select_mux.sv
// pair_select_mux: registered selector that outputs one channel pair from din, chosen by se or by a scan pointer, with valid/ready handshaking; PAIR_MUX_PARITY_EN adds even-parity outputs m_par/n_par
module pair_select_mux #(
  parameter int W = 4,
  parameter int NCH = 4,
  localparam int SEL_W = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] din,
  input  logic [SEL_W-1:0] se,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     m_out,
  output logic [W-1:0]     n_out,
  output logic [SEL_W-1:0] pair_idx,
  output logic             sel_err,
  input  logic             out_ready,
  output logic             out_valid
`ifdef PAIR_MUX_PARITY_EN
  ,
  output logic             m_par,
  output logic             n_par
`endif
);
  logic [SEL_W-1:0] r_scan_ptr;
  logic [SEL_W-1:0] w_idx;
  logic [W-1:0]     w_m;
  logic [W-1:0]     w_n;
  logic             w_err;
  logic             w_accept;
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_idx = mode ? r_scan_ptr : se;
  // Map the index to its channel pair; an index with no pair selects zeros and flags an error
  always_comb begin
    w_err = 1'b1;
    w_m = '0;
    w_n = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_idx == SEL_W'(k)) begin
        w_err = 1'b0;
        w_m = din[(k == NCH-1 ? 0 : k)*W +: W];
        w_n = din[(k == NCH-1 ? NCH-1 : k+1)*W +: W];
      end
    end
  end
  // Scan pointer: held at 0 in manual mode so a new scan always starts at pair 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_scan_ptr <= '0;
    else if (!mode) r_scan_ptr <= '0;
    else if (w_accept) r_scan_ptr <= (r_scan_ptr == SEL_W'(NCH-1)) ? '0 : r_scan_ptr + 1'b1;
  end
  // Output beat register: load on accept, drop valid on a bare dequeue, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      m_out <= '0;
      n_out <= '0;
      pair_idx <= '0;
      sel_err <= 1'b0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      m_out <= w_m;
      n_out <= w_n;
      pair_idx <= w_idx;
      sel_err <= w_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef PAIR_MUX_PARITY_EN
  // Parity travels with the data beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_par <= 1'b0;
      n_par <= 1'b0;
    end else if (w_accept) begin
      m_par <= ^w_m;
      n_par <= ^w_n;
    end
  end
`endif
endmodule

// File: tb/tb_pair_select_mux.sv
// tb_pair_select_mux: random and directed checks of pair_select_mux (NCH=4 and NCH=3) against a behavioural model
module tb_pair_select_mux;
  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] din = 0;
  logic [1:0]  se = 0;
  logic        mode = 0;
  logic        in_valid = 0;
  logic        out_ready = 0;
  logic        rdy4, rdy3, v4, v3, e4, e3;
  logic [3:0]  m4, n4, m3, n3;
  logic [1:0]  i4, i3;
`ifdef PAIR_MUX_PARITY_EN
  logic        mp4, np4, mp3, np3;
`endif
  int checks = 0;
  int errors = 0;
  int ev[2] = '{0, 0};
  int em[2] = '{0, 0};
  int en[2] = '{0, 0};
  int ei[2] = '{0, 0};
  int ee[2] = '{0, 0};
  int esc[2] = '{0, 0};
  int nch[2] = '{4, 3};
  int m_idx;
  bit m_acc;

  always #5 clk = ~clk;

  pair_select_mux #(.W(4), .NCH(4)) u4 (
    .clk(clk), .rst(rst), .din(din), .se(se), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy4), .m_out(m4), .n_out(n4), .pair_idx(i4), .sel_err(e4),
    .out_ready(out_ready), .out_valid(v4)
`ifdef PAIR_MUX_PARITY_EN
    , .m_par(mp4), .n_par(np4)
`endif
  );

  pair_select_mux #(.W(4), .NCH(3)) u3 (
    .clk(clk), .rst(rst), .din(din[11:0]), .se(se), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy3), .m_out(m3), .n_out(n3), .pair_idx(i3), .sel_err(e3),
    .out_ready(out_ready), .out_valid(v3)
`ifdef PAIR_MUX_PARITY_EN
    , .m_par(mp3), .n_par(np3)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ch(input logic [15:0] d, input int k);
    return int'((d >> (4 * k)) & 16'hF);
  endfunction

  function automatic int parity(input int v);
    return int'(^v[3:0]);
  endfunction

  task automatic pair(input logic [15:0] d, input int idx, input int nc, output int m, output int n, output int e);
    if (idx >= nc) begin
      m = 0; n = 0; e = 1;
    end else begin
      m = ch(d, idx == nc - 1 ? 0 : idx);
      n = ch(d, idx == nc - 1 ? nc - 1 : idx + 1);
      e = 0;
    end
  endtask

  always @(posedge rst) begin
    for (int u = 0; u < 2; u++) begin
      ev[u] = 0; em[u] = 0; en[u] = 0; ei[u] = 0; ee[u] = 0; esc[u] = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 2; u++) begin
        m_acc = in_valid && (ev[u] == 0 || out_ready);
        m_idx = mode ? esc[u] : int'(se);
        if (m_acc) begin
          pair(din, m_idx, nch[u], em[u], en[u], ee[u]);
          ei[u] = m_idx;
          ev[u] = 1;
        end else if (out_ready) ev[u] = 0;
        esc[u] = !mode ? 0 : m_acc ? (esc[u] + 1) % nch[u] : esc[u];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid4", int'(v4), ev[0]);
      chk("ready4", int'(rdy4), int'(ev[0] == 0 || out_ready));
      chk("m4", int'(m4), em[0]);
      chk("n4", int'(n4), en[0]);
      chk("idx4", int'(i4), ei[0]);
      chk("err4", int'(e4), ee[0]);
      chk("valid3", int'(v3), ev[1]);
      chk("ready3", int'(rdy3), int'(ev[1] == 0 || out_ready));
      chk("m3", int'(m3), em[1]);
      chk("n3", int'(n3), en[1]);
      chk("idx3", int'(i3), ei[1]);
      chk("err3", int'(e3), ee[1]);
`ifdef PAIR_MUX_PARITY_EN
      chk("mpar4", int'(mp4), parity(em[0]));
      chk("npar4", int'(np4), parity(en[0]));
      chk("mpar3", int'(mp3), parity(em[1]));
      chk("npar3", int'(np3), parity(en[1]));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sm[4] = '{1, 2, 3, 1};
    int sn[4] = '{2, 3, 4, 4};
    int tm[4] = '{1, 2, 1, 0};
    int tn[4] = '{2, 3, 3, 0};
    int te[4] = '{0, 0, 0, 1};
    int sidx[6] = '{0, 1, 2, 3, 0, 1};
    repeat (2) tick();
    chk("rst_valid", int'(v4), 0);
    chk("rst_ready", int'(rdy4), 1);
    chk("rst_m", int'(m4), 0);
    chk("rst_idx", int'(i4), 0);
    chk("rst_err", int'(e4), 0);
    rst = 0;
    din = 16'h4321;
    in_valid = 1;
    out_ready = 1;
    for (int s = 0; s < 4; s++) begin
      se = 2'(s);
      tick();
      chk("sweep_m", int'(m4), sm[s]);
      chk("sweep_n", int'(n4), sn[s]);
      chk("sweep_idx", int'(i4), s);
      chk("sweep_err", int'(e4), 0);
      chk("sweep3_m", int'(m3), tm[s]);
      chk("sweep3_n", int'(n3), tn[s]);
      chk("sweep3_err", int'(e3), te[s]);
    end
    se = 1;
    tick();
    out_ready = 0;
    se = 2;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_ready", int'(rdy4), 0);
      chk("bp_m", int'(m4), 2);
      chk("bp_n", int'(n4), 3);
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", int'(rdy4), 1);
    tick();
    chk("bp_next_m", int'(m4), 3);
    chk("bp_next_n", int'(n4), 4);
    mode = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("scan_idx", int'(i4), sidx[c]);
    end
    mode = 0;
    se = 2;
    tick();
    mode = 1;
    tick();
    chk("scan_restart_idx", int'(i4), 0);
    mode = 0;
    se = 3;
    out_ready = 0;
    tick();
    chk("pre_rst_valid", int'(v4), 1);
    #2 rst = 1;
    #1;
    chk("arst_valid", int'(v4), 0);
    chk("arst_m", int'(m4), 0);
    chk("arst_n", int'(n4), 0);
    chk("arst_idx", int'(i4), 0);
    chk("arst_ready", int'(rdy4), 1);
    rst = 0;
    se = 1;
    tick();
    chk("first_accept_m", int'(m4), 2);
    chk("first_accept_valid", int'(v4), 1);
`ifdef PAIR_MUX_PARITY_EN
    out_ready = 1;
    din = 16'h1007;
    se = 3;
    tick();
    chk("par_m", int'(mp4), 1);
    chk("par_n", int'(np4), 1);
`endif
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      se = 2'($urandom_range(0, 3));
      din = 16'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1;
        #1 rst = 0;
      end
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
